// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, one step per clock, valid/ready on both sides.
// Optional feature: define BOOTH_SIGNED_SEL_EN to add i_is_signed (per-operation signed/unsigned select).
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
`ifdef BOOTH_SIGNED_SEL_EN
    input  logic               i_is_signed,
`endif
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);
    // One guard bit above the operand width keeps A from overflowing, even for min x min.
    localparam int N  = WIDTH + 1;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [N-1:0]       r_a, r_q, r_m;
    logic               r_q1;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic               w_accept, w_last, w_sext;
    logic [N-1:0]       w_sum, w_a_nxt, w_q_nxt;

`ifdef BOOTH_SIGNED_SEL_EN
    assign w_sext = i_is_signed;
`else
    assign w_sext = 1'b1;
`endif

    assign w_accept  = i_in_valid && o_in_ready;
    assign w_last    = r_cnt == CW'(N - 1);
    assign o_product = r_product;

    // Booth recode of {Q[0],Q_1}: add M, subtract M, or keep A; then arithmetic shift of {A,Q,Q_1}.
    always_comb begin
        w_sum   = ({r_q[0], r_q1} == 2'b01) ? r_a + r_m :
                  ({r_q[0], r_q1} == 2'b10) ? r_a - r_m : r_a;
        w_a_nxt = {w_sum[N-1], w_sum[N-1:1]};
        w_q_nxt = {w_sum[0], r_q[N-1:1]};
    end

    // Next-state and handshake outputs; in_ready is held low while reset is asserted.
    always_comb begin
        w_state_nxt = IDLE;
        o_in_ready  = (r_state == IDLE) && i_rst_n;
        o_out_valid = r_state == DONE;
        o_busy      = r_state != IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_accept ? CALC : IDLE;
            CALC:    w_state_nxt = w_last ? DONE : CALC;
            DONE:    w_state_nxt = i_out_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Operand load on accept, one Booth step per CALC cycle, product captured on the last step.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a       <= '0;
            r_q       <= '0;
            r_m       <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a   <= '0;
            r_m   <= {w_sext & i_multiplicand[WIDTH-1], i_multiplicand};
            r_q   <= {w_sext & i_multiplier[WIDTH-1], i_multiplier};
            r_q1  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == CALC) begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_q1  <= r_q[0];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_product <= {w_a_nxt[WIDTH-2:0], w_q_nxt};
        end
    end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: randomized and directed checks of booth_mult_seq against an integer-arithmetic model.
module tb_booth_mult_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv = 1'b0, ir, ov, ordy = 1'b0, busy, sg = 1'b1;
    logic [7:0]  m = '0, q = '0;
    logic [15:0] p;
    logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b0, busy16, sg16 = 1'b1;
    logic [15:0] m16 = '0, q16 = '0;
    logic [31:0] p16;
    int          n_vec = 0, n_err = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_mult_seq #(.WIDTH(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv), .o_in_ready(ir),
        .i_multiplicand(m), .i_multiplier(q),
`ifdef BOOTH_SIGNED_SEL_EN
        .i_is_signed(sg),
`endif
        .o_out_valid(ov), .i_out_ready(ordy), .o_product(p), .o_busy(busy)
    );

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv16), .o_in_ready(ir16),
        .i_multiplicand(m16), .i_multiplier(q16),
`ifdef BOOTH_SIGNED_SEL_EN
        .i_is_signed(sg16),
`endif
        .o_out_valid(ov16), .i_out_ready(ordy16), .o_product(p16), .o_busy(busy16)
    );

    // Reference: interpret w-bit operands as signed or unsigned integers and multiply.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input int w, input logic s);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        if (s && a[w-1]) x = x - (longint'(1) << w);
        if (s && b[w-1]) y = y - (longint'(1) << w);
        return 64'(x * y);
    endfunction

    task automatic start8(input logic [7:0] mm, input logic [7:0] qq, input logic s, output logic rdy);
        m = mm; q = qq; sg = s; iv = 1'b1; rdy = ir;
        @(posedge clk); #1;
        iv = 1'b0; m = 8'($urandom); q = 8'($urandom);
    endtask

    task automatic wait8(output int lat, output int bad);
        lat = 0; bad = 0;
        while (ov !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
            if (ir !== 1'b0 || busy !== 1'b1) bad++;
        end
    endtask

    task automatic drain8(output logic [2:0] st);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0; st = {ov, ir, busy};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if ({ir, ov, busy} !== 3'b000) begin n_err++; $display("FAIL reset flags: got ir/ov/busy=%b want 000", {ir, ov, busy}); end
        n_vec++; if (p !== 16'h0) begin n_err++; $display("FAIL reset product: got %h want 0000", p); end
        n_vec++; if ({ov16, busy16, p16} !== 34'h0) begin n_err++; $display("FAIL reset16: got ov=%b busy=%b p=%h want 0", ov16, busy16, p16); end
        rst_n = 1'b1; #1;
        n_vec++; if (ir !== 1'b1 || ir16 !== 1'b1) begin n_err++; $display("FAIL reset release in_ready: got %b/%b want 1/1", ir, ir16); end
    endtask

    task automatic test_known();
        logic [7:0]  tm[4] = '{8'd7, 8'h80, 8'd0, 8'h7F};
        logic [7:0]  tq[4] = '{8'hFD, 8'h80, 8'h5A, 8'h80};
        logic [15:0] tp[4] = '{16'hFFEB, 16'h4000, 16'h0000, 16'hC080};
        logic rdy; int lat, bad; logic [2:0] st;
        for (int i = 0; i < 4; i++) begin
            start8(tm[i], tq[i], 1'b1, rdy);
            wait8(lat, bad);
            n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL known[%0d] accept: in_ready %b want 1", i, rdy); end
            n_vec++; if (lat != 9) begin n_err++; $display("FAIL known[%0d] latency: got %0d want 9", i, lat); end
            n_vec++; if (bad != 0) begin n_err++; $display("FAIL known[%0d] busy/in_ready in calc: %0d bad cycles want 0", i, bad); end
            n_vec++; if (p !== tp[i]) begin n_err++; $display("FAIL known[%0d] product: got %h want %h", i, p, tp[i]); end
            drain8(st);
            n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL known[%0d] release: ov/ir/busy=%b want 010", i, st); end
        end
    endtask

    task automatic test_random();
        logic [7:0] mm, qq; logic s, rdy; int lat, bad; logic [2:0] st; logic [63:0] e;
        for (int i = 0; i < 40; i++) begin
            mm = 8'($urandom); qq = 8'($urandom);
            if (i % 8 == 1) mm = 8'h80;
            if (i % 8 == 2) qq = 8'h80;
            if (i % 8 == 3) qq = 8'hFF;
`ifdef BOOTH_SIGNED_SEL_EN
            s = 1'($urandom);
`else
            s = 1'b1;
`endif
            e = model({24'd0, mm}, {24'd0, qq}, 8, s);
            start8(mm, qq, s, rdy);
            wait8(lat, bad);
            n_vec++; if (lat != 9 || bad != 0 || rdy !== 1'b1) begin n_err++; $display("FAIL rand[%0d] timing: lat=%0d bad=%0d rdy=%b want 9/0/1", i, lat, bad, rdy); end
            n_vec++; if (p !== e[15:0]) begin n_err++; $display("FAIL rand[%0d] product %h*%h s=%b: got %h want %h", i, mm, qq, s, p, e[15:0]); end
            drain8(st);
            n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL rand[%0d] release: ov/ir/busy=%b want 010", i, st); end
        end
    endtask

    task automatic test_backpressure();
        logic rdy; int lat, bad; logic [2:0] st;
        start8(8'd5, 8'd6, 1'b1, rdy);
        wait8(lat, bad);
        n_vec++; if (lat != 9) begin n_err++; $display("FAIL bp latency: got %0d want 9", lat); end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            iv = 1'b1; m = 8'd9; q = 8'd9;
            @(posedge clk); #1;
            if (p !== 16'h001E || ov !== 1'b1 || ir !== 1'b0) bad++;
        end
        iv = 1'b0;
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp hold: %0d bad cycles want 0 (p=%h ov=%b ir=%b)", bad, p, ov, ir); end
        drain8(st);
        n_vec++; if (st !== 3'b010) begin n_err++; $display("FAIL bp release: ov/ir/busy=%b want 010", st); end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0 || p !== 16'h001E) begin n_err++; $display("FAIL bp ignored input: busy=%b p=%h want 0/001e", busy, p); end
    endtask

    task automatic test_reset_mid();
        logic rdy; int lat, bad; logic [2:0] st;
        start8(8'd9, 8'd9, 1'b1, rdy);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_vec++; if ({ov, busy} !== 2'b00 || p !== 16'h0) begin n_err++; $display("FAIL midreset state: ov=%b busy=%b p=%h want 0/0/0000", ov, busy, p); end
        rst_n = 1'b1; #1;
        n_vec++; if (ir !== 1'b1) begin n_err++; $display("FAIL midreset in_ready: got %b want 1", ir); end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ov !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL midreset stray output: %0d bad cycles want 0", bad); end
        start8(8'd3, 8'd4, 1'b1, rdy);
        wait8(lat, bad);
        n_vec++; if (p !== 16'h000C || lat != 9) begin n_err++; $display("FAIL midreset fresh: p=%h lat=%0d want 000c/9", p, lat); end
        drain8(st);
    endtask

    task automatic test_back_to_back();
        logic [63:0] e; int acc, prev, n; logic [7:0] mm, qq;
        prev = -1;
        ordy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            mm = 8'($urandom); qq = 8'($urandom);
            e = model({24'd0, mm}, {24'd0, qq}, 8, 1'b1);
            m = mm; q = qq; sg = 1'b1; iv = 1'b1;
            n = 0;
            while (ir !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
            @(posedge clk); acc = cyc; #1;
            iv = 1'b0;
            n_vec++; if (prev >= 0 && acc - prev != 11) begin n_err++; $display("FAIL b2b[%0d] spacing: got %0d want 11", k, acc - prev); end
            prev = acc;
            n = 0;
            while (ov !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
            n_vec++; if (p !== e[15:0] || n != 9) begin n_err++; $display("FAIL b2b[%0d] product: got %h lat %0d want %h lat 9", k, p, n, e[15:0]); end
        end
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic test_width16();
        logic [15:0] tm[4] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF};
        logic [15:0] tq[4] = '{16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF};
        logic [15:0] mm, qq; logic rdy; int lat; logic [63:0] e;
        for (int i = 0; i < 10; i++) begin
            mm = (i < 4) ? tm[i] : 16'($urandom);
            qq = (i < 4) ? tq[i] : 16'($urandom);
            e = model({16'd0, mm}, {16'd0, qq}, 16, 1'b1);
            m16 = mm; q16 = qq; sg16 = 1'b1; iv16 = 1'b1; rdy = ir16;
            @(posedge clk); #1;
            iv16 = 1'b0;
            lat = 0;
            while (ov16 !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
            n_vec++; if (lat != 17 || rdy !== 1'b1) begin n_err++; $display("FAIL w16[%0d] timing: lat=%0d rdy=%b want 17/1", i, lat, rdy); end
            n_vec++; if (p16 !== e[31:0]) begin n_err++; $display("FAIL w16[%0d] product %h*%h: got %h want %h", i, mm, qq, p16, e[31:0]); end
            if (i == 0) begin
                n_vec++; if (p16 !== 32'hC0008000) begin n_err++; $display("FAIL w16 min*max: got %h want c0008000", p16); end
            end
            ordy16 = 1'b1;
            @(posedge clk); #1;
            ordy16 = 1'b0;
            n_vec++; if (ov16 !== 1'b0 || ir16 !== 1'b1) begin n_err++; $display("FAIL w16[%0d] release: ov=%b ir=%b want 0/1", i, ov16, ir16); end
        end
    endtask

`ifdef BOOTH_SIGNED_SEL_EN
    task automatic test_unsigned();
        logic rdy; int lat, bad; logic [2:0] st;
        start8(8'hFF, 8'hFF, 1'b0, rdy);
        wait8(lat, bad);
        n_vec++; if (p !== 16'hFE01 || lat != 9) begin n_err++; $display("FAIL unsigned ff*ff: got %h lat %0d want fe01 lat 9", p, lat); end
        drain8(st);
        start8(8'hFF, 8'hFF, 1'b1, rdy);
        wait8(lat, bad);
        n_vec++; if (p !== 16'h0001) begin n_err++; $display("FAIL signed ff*ff: got %h want 0001", p); end
        drain8(st);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_known();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_width16();
`ifdef BOOTH_SIGNED_SEL_EN
        test_unsigned();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
